// File: rtl/adpll_settle_monitor.sv
// Lock/settling monitor for the ADPLL: measures settle and relock time in reference cycles,
// flags timeout and lock loss. Define SETTLE_MON_STATS_EN to add windowed TDC min/max statistics.
module adpll_settle_monitor #(
  parameter int unsigned TDC_W      = 12,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned TIMEOUT    = 2**20,
  parameter int unsigned N_WIN_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             channel_lock,
  input  logic [TDC_W-1:0] tdc_word,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] settle_cycles,
  output logic             settle_valid,
  output logic             timeout,
  output logic             lock_lost,
  output logic [TDC_W-1:0] tdc_min,
  output logic [TDC_W-1:0] tdc_max,
  output logic             stats_valid
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_TIMEOUT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] settle_d;
  logic             settle_valid_d, timeout_d, lock_lost_d;
  logic             en_q, rise;

  assign rise  = en & ~en_q;
  assign state = state_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt;
    settle_d       = settle_cycles;
    settle_valid_d = 1'b0;
    timeout_d      = timeout;
    lock_lost_d    = lock_lost;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (rise) begin
      state_d     = ST_SETTLING;
      cnt_d       = CNT_W'(1);
      timeout_d   = 1'b0;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_SETTLING: begin
          // lock wins over timeout when both land on the same edge
          if (channel_lock) begin
            settle_d       = cnt;
            settle_valid_d = 1'b1;
            state_d        = ST_LOCKED;
          end else if (cnt == TIMEOUT_C) begin
            timeout_d = 1'b1;
            state_d   = ST_TIMEOUT;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!channel_lock) begin
            lock_lost_d = 1'b1;
            cnt_d       = CNT_W'(1);
            state_d     = ST_SETTLING;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt           <= '0;
      en_q          <= 1'b0;
      settle_cycles <= '0;
      settle_valid  <= 1'b0;
      timeout       <= 1'b0;
      lock_lost     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt           <= cnt_d;
      en_q          <= en;
      settle_cycles <= settle_d;
      settle_valid  <= settle_valid_d;
      timeout       <= timeout_d;
      lock_lost     <= lock_lost_d;
    end
  end

`ifdef SETTLE_MON_STATS_EN
  logic                  sample;
  logic                  win_first;
  logic [N_WIN_LOG2-1:0] win_cnt;
  logic [TDC_W-1:0]      run_min, run_max, cur_min, cur_max;

  // a sample is taken only on edges that stay in LOCKED; leaving drops the partial window
  assign sample    = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
  assign win_first = (win_cnt == '0);

  always_comb begin
    cur_min = run_min;
    cur_max = run_max;
    if (win_first || (tdc_word < run_min)) cur_min = tdc_word;
    if (win_first || (tdc_word > run_max)) cur_max = tdc_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      run_min     <= '0;
      run_max     <= '0;
      tdc_min     <= '0;
      tdc_max     <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (sample) begin
        run_min <= cur_min;
        run_max <= cur_max;
        win_cnt <= win_cnt + N_WIN_LOG2'(1);
        if (win_cnt == '1) begin
          tdc_min     <= cur_min;
          tdc_max     <= cur_max;
          stats_valid <= 1'b1;
        end
      end else begin
        win_cnt <= '0;
      end
    end
  end
`else
  logic stats_unused;
  assign stats_unused = ^tdc_word;
  assign tdc_min      = '0;
  assign tdc_max      = '0;
  assign stats_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_settle_monitor.sv
// Bench for adpll_settle_monitor: table of settle scenarios plus hand sequences for timeout,
// relock, same-edge lock, statistics windows and mid-run reset. Settle pulses checked via a queue.
module tb_adpll_settle_monitor;
  localparam int unsigned TDC_W = 12;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned TO    = 100;
  localparam int unsigned NW    = 4;
`ifdef SETTLE_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             channel_lock;
  logic [TDC_W-1:0] tdc_word;
  logic [1:0]       state;
  logic [CNT_W-1:0] settle_cycles;
  logic             settle_valid;
  logic             timeout;
  logic             lock_lost;
  logic [TDC_W-1:0] tdc_min;
  logic [TDC_W-1:0] tdc_max;
  logic             stats_valid;

  adpll_settle_monitor #(
    .TDC_W(TDC_W),
    .CNT_W(CNT_W),
    .TIMEOUT(TO),
    .N_WIN_LOG2(NW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .channel_lock(channel_lock),
    .tdc_word(tdc_word),
    .state(state),
    .settle_cycles(settle_cycles),
    .settle_valid(settle_valid),
    .timeout(timeout),
    .lock_lost(lock_lost),
    .tdc_min(tdc_min),
    .tdc_max(tdc_max),
    .stats_valid(stats_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];

  typedef struct {
    int unsigned delay;
    int unsigned exp_state;
    int unsigned exp_settle;
    bit          exp_pulse;
    bit          exp_to;
  } row_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later; every settle pulse is matched against the queue.
  task automatic tick();
    @(posedge clk);
    #1;
    if (settle_valid) begin
      if (exp_q.size() == 0) chk("spurious settle_valid", settle_valid, 0);
      else chk("settle_cycles at pulse", settle_cycles, exp_q.pop_front());
    end
  endtask

  task automatic relock(input int unsigned d);
    channel_lock = 1'b0;
    tick();
    chk("lock_lost after drop", lock_lost, 1);
    chk("state after drop", state, 1);
    for (int unsigned i = 1; i < d; i++) tick();
    channel_lock = 1'b1;
    exp_q.push_back(d);
    tick();
    chk("state after relock", state, 2);
    chk("relock settle_cycles", settle_cycles, d);
    chk("lock_lost sticky", lock_lost, 1);
  endtask

  task automatic window(input int unsigned start, input int step);
    int unsigned v, mn, mx;
    mn = '1;
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      v = unsigned'(int'(start) + step * i);
      if (v < mn) mn = v;
      if (v > mx) mx = v;
      tdc_word = TDC_W'(v);
      tick();
      if (i < 15) chk("stats_valid mid-window", stats_valid, 0);
    end
    chk("stats_valid end of window", stats_valid, STATS);
    chk("tdc_min", tdc_min, STATS ? mn : 0);
    chk("tdc_max", tdc_max, STATS ? mx : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[5];
    rows[0] = '{delay: 1,   exp_state: 2, exp_settle: 1,   exp_pulse: 1'b1, exp_to: 1'b0};
    rows[1] = '{delay: 2,   exp_state: 2, exp_settle: 2,   exp_pulse: 1'b1, exp_to: 1'b0};
    rows[2] = '{delay: 37,  exp_state: 2, exp_settle: 37,  exp_pulse: 1'b1, exp_to: 1'b0};
    rows[3] = '{delay: 100, exp_state: 2, exp_settle: 100, exp_pulse: 1'b1, exp_to: 1'b0};
    rows[4] = '{delay: 101, exp_state: 3, exp_settle: 0,   exp_pulse: 1'b0, exp_to: 1'b1};

    rst_n = 1'b0; en = 1'b0; channel_lock = 1'b0; tdc_word = '0;
    repeat (3) tick();
    chk("reset state", state, 0);
    chk("reset settle_cycles", settle_cycles, 0);
    chk("reset settle_valid", settle_valid, 0);
    chk("reset timeout", timeout, 0);
    chk("reset lock_lost", lock_lost, 0);
    chk("reset tdc_min", tdc_min, 0);
    chk("reset tdc_max", tdc_max, 0);
    chk("reset stats_valid", stats_valid, 0);
    rst_n = 1'b1;
    repeat (6) tick();

    // Settle scenarios: lock first sampled high `delay` edges after the rise edge
    for (int r = 0; r < 5; r++) begin
      en = 1'b1; channel_lock = 1'b0;
      tick();
      chk("state after rise", state, 1);
      for (int unsigned i = 1; i < rows[r].delay; i++) tick();
      channel_lock = 1'b1;
      if (rows[r].exp_pulse) exp_q.push_back(rows[r].exp_settle);
      tick();
      chk("row state", state, rows[r].exp_state);
      chk("row timeout", timeout, rows[r].exp_to);
      if (rows[r].exp_pulse) chk("row settle_cycles", settle_cycles, rows[r].exp_settle);
      tick();
      chk("row state hold", state, rows[r].exp_state);
      en = 1'b0; channel_lock = 1'b0;
      tick();
      chk("row state after en low", state, 0);
      chk("row timeout retained", timeout, rows[r].exp_to);
    end

    // Timeout lands exactly TO edges after the rise; next rise clears the flag
    en = 1'b1;
    tick();
    chk("timeout cleared by rise", timeout, 0);
    repeat (98) tick();
    tick();
    chk("state at TO-1", state, 1);
    chk("timeout at TO-1", timeout, 0);
    tick();
    chk("state at TO", state, 3);
    chk("timeout at TO", timeout, 1);
    en = 1'b0;
    tick();
    chk("state idle after timeout", state, 0);
    chk("timeout held in idle", timeout, 1);
    chk("settle_cycles retained", settle_cycles, 100);

    // Lock loss and relock measurement
    en = 1'b1;
    tick();
    chk("timeout cleared", timeout, 0);
    channel_lock = 1'b1;
    exp_q.push_back(1);
    tick();
    chk("locked", state, 2);
    chk("lock_lost clear", lock_lost, 0);
    relock(1);
    relock(6);
    relock(3);
    en = 1'b0; channel_lock = 1'b0;
    tick();
    chk("idle after relocks", state, 0);
    chk("lock_lost retained", lock_lost, 1);

    // en and channel_lock rise together
    en = 1'b1; channel_lock = 1'b1;
    tick();
    chk("same-edge state", state, 1);
    chk("lock_lost cleared by rise", lock_lost, 0);
    exp_q.push_back(1);
    tick();
    chk("same-edge locked", state, 2);
    chk("same-edge settle_cycles", settle_cycles, 1);

    // Statistics: rising ramp, falling ramp, then a partial window that must be discarded
    window(100, 1);
    window(200, -3);
    for (int i = 0; i < 5; i++) begin
      tdc_word = TDC_W'(10 + i);
      tick();
    end
    channel_lock = 1'b0;
    tick();
    channel_lock = 1'b1;
    exp_q.push_back(1);
    tick();
    chk("stats relocked", state, 2);
    window(300, 1);
    tick();
    chk("stats_valid one cycle", stats_valid, 0);

    // Reset in the middle of SETTLING
    en = 1'b0; channel_lock = 1'b0;
    tick();
    en = 1'b1;
    repeat (3) tick();
    chk("pre-reset settling", state, 1);
    rst_n = 1'b0;
    tick();
    chk("mid reset state", state, 0);
    chk("mid reset settle_cycles", settle_cycles, 0);
    chk("mid reset settle_valid", settle_valid, 0);
    chk("mid reset timeout", timeout, 0);
    chk("mid reset lock_lost", lock_lost, 0);
    chk("mid reset tdc_min", tdc_min, 0);
    chk("mid reset tdc_max", tdc_max, 0);
    chk("mid reset stats_valid", stats_valid, 0);
    rst_n = 1'b1; en = 1'b0; channel_lock = 1'b1;
    repeat (5) tick();
    chk("idle after reset", state, 0);
    chk("settle_cycles after reset", settle_cycles, 0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
